// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types for the iterative comparator (op encoding, FSM states).
package cmp_pkg;

    typedef enum logic [1:0] {
        CMP_SLT  = 2'b00,
        CMP_SLTU = 2'b01,
        CMP_SGE  = 2'b10,
        CMP_SGEU = 2'b11
    } cmp_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } cmp_state_t;

    // Signed ops have op[0] clear.
    function automatic logic op_is_signed(cmp_op_t op);
        return ~op[0];
    endfunction

    // SGE/SGEU report the complement of less-than.
    function automatic logic op_is_ge(cmp_op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/cmp_iter_if.sv
// cmp_iter_if: request/result handshake bundle for cmp_iter.
interface cmp_iter_if
    import cmp_pkg::*;
#(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    cmp_op_t      op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out;
    logic         eq;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, out, eq
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, out, eq
    );
endinterface

// File: rtl/cmp_chunk.sv
// cmp_chunk: combinational unsigned compare of one W-bit slice.
module cmp_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         lt_o,
    output logic         eq_o
);

    // Plain magnitude compare; sign handling is done before slicing.
    always_comb begin
        lt_o = (a_i < b_i);
        eq_o = (a_i == b_i);
    end

endmodule

// File: rtl/cmp_iter.sv
// cmp_iter: iterative comparator, one CHUNK-bit slice per cycle, MSB slice first.
// Build macro CMP_ITER_EARLY_EXIT_EN: leave BUSY as soon as a slice differs;
// without it the walk always covers all K slices.
//
// state   | meaning
// ST_IDLE | waiting for a request, in_ready high
// ST_BUSY | comparing slice idx_q, walking from K-1 down to 0
// ST_DONE | result presented, held until out_ready
module cmp_iter
    import cmp_pkg::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    cmp_iter_if.slave bus
);

    localparam int K  = N / CHUNK;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] IDX_TOP  = IW'(K - 1);
    localparam logic [N-1:0]  SIGN_BIT = {1'b1, {(N-1){1'b0}}};

    cmp_state_t    state_q, state_d;
    logic [N-1:0]  a_q, b_q;
    cmp_op_t       op_q;
    logic [IW-1:0] idx_q, idx_d;
    logic          lt_q, lt_d;
    logic          diff_q, diff_d;   // an unequal slice has been seen

    logic          accept;
    logic          slice_lt, slice_eq;
    logic          last_slice;
    logic          leave_busy;
    logic          done_w;
    logic          pred;

    assign accept     = bus.in_valid && (state_q == ST_IDLE);
    assign last_slice = (idx_q == '0);

    cmp_chunk #(.W(CHUNK)) u_chunk (
        .a_i  (a_q[int'(idx_q) * CHUNK +: CHUNK]),
        .b_i  (b_q[int'(idx_q) * CHUNK +: CHUNK]),
        .lt_o (slice_lt),
        .eq_o (slice_eq)
    );

`ifdef CMP_ITER_EARLY_EXIT_EN
    assign leave_busy = !slice_eq || last_slice;
`else
    assign leave_busy = last_slice;
`endif

    // State, walk index and decision registers; operands captured on accept.
    // Flipping the sign bit turns a signed compare into an unsigned one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_TOP;
            lt_q    <= 1'b0;
            diff_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= CMP_SLT;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lt_q    <= lt_d;
            diff_q  <= diff_d;
            if (accept) begin
                a_q  <= op_is_signed(bus.op) ? (bus.a ^ SIGN_BIT) : bus.a;
                b_q  <= op_is_signed(bus.op) ? (bus.b ^ SIGN_BIT) : bus.b;
                op_q <= bus.op;
            end
        end
    end

    // Next-state and decision logic; the first unequal slice fixes lt.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lt_d    = lt_q;
        diff_d  = diff_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_BUSY;
                    idx_d   = IDX_TOP;
                    lt_d    = 1'b0;
                    diff_d  = 1'b0;
                end
            end
            ST_BUSY: begin
                if (!diff_q && !slice_eq) begin
                    diff_d = 1'b1;
                    lt_d   = slice_lt;
                end
                if (leave_busy) begin
                    state_d = ST_DONE;
                    idx_d   = IDX_TOP;
                end else begin
                    idx_d   = idx_q - IW'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode straight from registers so they hold steady in DONE.
    always_comb begin
        done_w        = (state_q == ST_DONE);
        pred          = op_is_ge(op_q) ? !lt_q : lt_q;
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = done_w;
        bus.out       = done_w ? N'(pred) : '0;
        bus.eq        = done_w && !diff_q;
    end

endmodule

// File: tb/tb_cmp_iter.sv
// tb_cmp_iter: randomized self-checking bench for cmp_iter (N=32, CHUNK=8).
// Define CMP_ITER_EARLY_EXIT_EN for both bench and RTL to check the early-exit build.
// Cycle n is the clock period ending at rising edge n; the accept edge is edge 0.
module tb_cmp_iter;
    import cmp_pkg::*;

    localparam int N     = 32;
    localparam int CHUNK = 8;
    localparam int K     = N / CHUNK;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    cmp_iter_if #(.N(N)) bus ();

    cmp_iter #(.N(N), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain signed/unsigned arithmetic on the whole operands.
    function automatic logic ref_pred(logic [N-1:0] a, logic [N-1:0] b, cmp_op_t op);
        logic lt;
        case (op)
            CMP_SLT, CMP_SGE: lt = ($signed(a) < $signed(b));
            default:          lt = (a < b);
        endcase
        return (op == CMP_SGE || op == CMP_SGEU) ? !lt : lt;
    endfunction

    // Reference latency in cycles after the accept edge until out_valid is seen.
    function automatic int ref_lat(logic [N-1:0] a, logic [N-1:0] b);
`ifdef CMP_ITER_EARLY_EXIT_EN
        logic [N-1:0] x;
        x = a ^ b;
        for (int j = 1; j <= K; j++) begin
            if (x[(K - j) * CHUNK +: CHUNK] != '0) return j + 1;
        end
`endif
        return K + 1;
    endfunction

    // Issue one request and wait for its result; lat = -1 on timeout.
    task automatic run_req(input logic [N-1:0] a_v, input logic [N-1:0] b_v, input cmp_op_t op_v,
                           output int lat, output logic [N-1:0] o_v, output logic e_v);
        int w;
        lat = -1;
        o_v = '1;
        e_v = 1'bx;
        bus.in_valid = 1'b1;
        bus.a  = a_v;
        bus.b  = b_v;
        bus.op = op_v;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a  = $urandom;
        bus.b  = $urandom;
        bus.op = cmp_op_t'(2'($urandom_range(0, 3)));
        for (int c = 1; c <= 40; c++) begin
            if (bus.out_valid) begin
                lat = c;
                o_v = bus.out;
                e_v = bus.eq;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = CMP_SLT;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out !== '0 || bus.eq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got out_valid=%b out=%h eq=%b, want 0/0/0",
                     bus.out_valid, bus.out, bus.eq);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_directed();
        logic [N-1:0] ta [4];
        logic [N-1:0] tb [4];
        cmp_op_t      top [4];
        logic         to [4];
        logic         te [4];
        int           tl [4];
        int lat;
        logic [N-1:0] o;
        logic e;
        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'h0000_0001; top[0] = CMP_SLT;  to[0] = 1'b1; te[0] = 1'b0; tl[0] = 2;
        ta[1] = 32'hFFFF_FFFF; tb[1] = 32'h0000_0001; top[1] = CMP_SLTU; to[1] = 1'b0; te[1] = 1'b0; tl[1] = 2;
        ta[2] = 32'h8000_0000; tb[2] = 32'h8000_0000; top[2] = CMP_SGE;  to[2] = 1'b1; te[2] = 1'b1; tl[2] = 5;
        ta[3] = 32'h0100_0000; tb[3] = 32'h0200_0000; top[3] = CMP_SLTU; to[3] = 1'b1; te[3] = 1'b0; tl[3] = 2;
`ifndef CMP_ITER_EARLY_EXIT_EN
        tl[0] = 5; tl[1] = 5; tl[3] = 5;
`endif
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_req(ta[i], tb[i], top[i], lat, o, e);
            n_cmp++;
            if (o !== {31'd0, to[i]} || e !== te[i]) begin
                n_bad++;
                $display("FAIL directed_%0d_result: got out=%h eq=%b, want out=%h eq=%b",
                         i, o, e, {31'd0, to[i]}, te[i]);
            end
            n_cmp++;
            if (lat != tl[i]) begin
                n_bad++;
                $display("FAIL directed_%0d_latency: got %0d, want %0d", i, lat, tl[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [N-1:0] a, b, o;
        logic e;
        cmp_op_t op;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            op = cmp_op_t'(2'($urandom_range(0, 3)));
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = {a[31:8], 8'($urandom)};
                2: b = a ^ 32'h8000_0000;
                default: b = $urandom;
            endcase
            run_req(a, b, op, lat, o, e);
            n_cmp++;
            if (o !== {31'd0, ref_pred(a, b, op)} || e !== (a == b)) begin
                n_bad++;
                $display("FAIL random_%0d_result a=%h b=%h op=%0d: got out=%h eq=%b, want out=%h eq=%b",
                         i, a, b, op, o, e, {31'd0, ref_pred(a, b, op)}, (a == b));
            end
            n_cmp++;
            if (lat != ref_lat(a, b)) begin
                n_bad++;
                $display("FAIL random_%0d_latency a=%h b=%h: got %0d, want %0d", i, a, b, lat, ref_lat(a, b));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        int lat;
        logic [N-1:0] o0;
        logic e0;
        bus.out_ready = 1'b0;
        run_req(32'h1234_5678, 32'h1234_0000, CMP_SGEU, lat, o0, e0);
        n_cmp++;
        if (lat < 0 || o0 !== 32'd1 || e0 !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_result: got lat=%0d out=%h eq=%b, want out=1 eq=0", lat, o0, e0);
        end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.a  = $urandom;
            bus.b  = $urandom;
            bus.op = cmp_op_t'(2'($urandom_range(0, 3)));
            @(negedge clk);
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out !== 32'd1 || bus.eq !== 1'b0 || bus.in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold_%0d: got out_valid=%b out=%h eq=%b in_ready=%b, want 1/1/0/0",
                         i, bus.out_valid, bus.out, bus.eq, bus.in_ready);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_release: got out_valid=%b in_ready=%b, want 0/1", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_no_ghost: got out_valid=%b in_ready=%b, want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        logic [N-1:0] o;
        logic e;
        logic seen;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a  = 32'h0000_0001;
        bus.b  = 32'h0000_0002;
        bus.op = CMP_SLTU;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        seen = bus.out_valid;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_in_ready: got %b, want 1", bus.in_ready);
        end
        for (int i = 0; i < K + 4; i++) begin
            if (bus.out_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_result: got out_valid seen=%b, want 0", seen);
        end
        run_req(32'd3, 32'd5, CMP_SLT, lat, o, e);
        n_cmp++;
        if (o !== 32'd1 || e !== 1'b0 || lat != ref_lat(32'd3, 32'd5)) begin
            n_bad++;
            $display("FAIL abort_next_req: got out=%h eq=%b lat=%0d, want out=1 eq=0 lat=%0d",
                     o, e, lat, ref_lat(32'd3, 32'd5));
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        localparam int NB = 12;
        logic [N-1:0] ra [NB];
        logic [N-1:0] rb [NB];
        cmp_op_t      rop [NB];
        logic [N:0]   exp_q [$];
        logic [N:0]   ex;
        int sent, got, cyc;
        logic advance;
        for (int i = 0; i < NB; i++) begin
            ra[i]  = $urandom;
            rb[i]  = (i % 3 == 0) ? ra[i] : $urandom;
            rop[i] = cmp_op_t'(2'($urandom_range(0, 3)));
        end
        bus.out_ready = 1'b1;
        sent = 0;
        got  = 0;
        advance = 1'b0;
        bus.in_valid = 1'b1;
        bus.a  = ra[0];
        bus.b  = rb[0];
        bus.op = rop[0];
        cyc = 0;
        while (got < NB && cyc < 400) begin
            if (advance) begin
                advance = 1'b0;
                if (sent < NB) begin
                    bus.a  = ra[sent];
                    bus.b  = rb[sent];
                    bus.op = rop[sent];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.in_ready && bus.out_valid) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b2b_ready_in_done: got in_ready=1 with out_valid=1, want in_ready=0");
            end
            if (bus.out_valid) begin
                ex = exp_q.size() > 0 ? exp_q.pop_front() : {1'b1, {N{1'b1}}};
                n_cmp++;
                if ({bus.eq, bus.out} !== ex) begin
                    n_bad++;
                    $display("FAIL b2b_result_%0d: got eq=%b out=%h, want eq=%b out=%h",
                             got, bus.eq, bus.out, ex[N], ex[N-1:0]);
                end
                got++;
            end
            if (bus.in_ready && bus.in_valid) begin
                exp_q.push_back({(ra[sent] == rb[sent]), 31'd0, ref_pred(ra[sent], rb[sent], rop[sent])});
                sent++;
                advance = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (got != NB || sent != NB) begin
            n_bad++;
            $display("FAIL b2b_count: got results=%0d accepted=%0d, want %0d/%0d", got, sent, NB, NB);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_reset_mid_busy();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
